elastic_stage_pipeline: RTL
===========================

Name: elastic_stage_pipeline

Overview:
- Five-stage instruction pipeline: fetch, decode, operands, execute, writeback.
- Data moves forward. Backpressure (ready) moves backward from the output consumer toward the instruction source.
- Replaces a global enable with per-stage valid/ready flow control. Bubbles collapse, so a stall at the output only blocks stages that are full.
- Sits between the instruction source and the retire/writeback consumer. Supports a synchronous flush for branch redirects.

Parameters:
- WIDTH, 9: instruction word width in bits.
- DEPTH, 5: number of stages; stage 0 = fetch, stage DEPTH-1 = writeback.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all in-flight instructions this cycle.
- in_valid  input  1  source presents an instruction.
- in_data  input  WIDTH  instruction from source.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  writeback stage holds a valid instruction.
- out_data  output  WIDTH  writeback stage instruction.
- out_ready  input  1  consumer accepts out_data this cycle.
- occupancy  output  CNT_W  number of valid stages.
- stalled  output  1  out_valid && !out_ready.

Behaviour:
- State per stage i: valid[i] (1 bit) and data[i] (WIDTH bits).
- Reset (rst=1 at posedge):
  - all valid[i]=0 and all data[i]=0.
  - Outputs after reset: out_valid=0, out_data=0, occupancy=0, stalled=0, in_ready=1 unless flush is asserted.
  - rst has priority over flush and over any transfer.
- Ready chain (combinational, backward):
  - rdy[DEPTH-1] = out_ready || !valid[DEPTH-1]
  - rdy[i] = rdy[i+1] || !valid[i]
  - in_ready = rdy[0] && !flush
- Output transfer: occurs when out_valid && out_ready. out_valid = valid[DEPTH-1] && !flush. out_data = data[DEPTH-1].
- Per-cycle update when rdy[i] is true:
  - Stage 0 loads in_valid/in_data.
  - Stage i>0 loads valid[i-1]/data[i-1].
  - data[i] only updates when the incoming valid is 1. Empty stages keep stale data; no spurious toggles.
- Hold: when rdy[i] is false, stage i holds valid and data unchanged. out_data is stable while stalled.
- Input accepted: only on in_valid && in_ready. If in_valid is high and in_ready low, the source must hold in_data.
- Latency: accepted instruction appears on out_valid exactly DEPTH cycles later with no stalls. Throughput is 1 per cycle.
- Bubble collapse: with out_ready=0 and k empty stages, the pipeline still accepts k further instructions before in_ready falls.
- Full: all valid=1 and out_ready=0 -> in_ready=0. Dropping out_ready while full stops every stage in the same cycle.
- Simultaneous full and out_ready=1: every stage advances, in_ready=1, so a new input and an output retire in the same cycle.
- Flush (flush=1, rst=0):
  - At posedge, all valid[i] are cleared.
  - No input accepted (in_ready=0) and no output transfer (out_valid=0) in that cycle.
  - data registers hold their values.
  - occupancy=0 the next cycle.
- Flush while stalled: the stalled instruction is discarded; the consumer never sees a handshake for it.
- Occupancy: popcount of valid[], registered (reflects state after the last edge). Range 0..DEPTH; never wraps.
- Ordering: instructions exit in acceptance order. No duplication or loss except by flush/rst.

Decomposition:
- Package elastic_pipe_pkg holds:
  - stage index constants ST_FETCH=0, ST_DECODE=1, ST_OPERANDS=2, ST_EXECUTE=3, ST_WRITEBACK=4
  - default WIDTH
  - typedef for the instruction word.
- Sub-module elastic_pipe_stage: one valid+data register with inputs up_valid, up_data, down_ready, flush, rst. It outputs valid, data, and the combinational rdy to the previous stage.
- Top level instantiates DEPTH stages in a generate loop and computes occupancy/stalled.

Test Plan:
- Reset mid-stream: feed 0x001..0x003, assert rst on cycle 2 -> cycle after: out_valid=0, out_data=0, occupancy=0, no later output of 0x001..0x003.
- Streaming: out_ready=1, in_valid=1 with 0x010,0x011,0x012 on consecutive cycles -> out_valid high with 0x010 exactly 5 cycles after its acceptance, then 0x011, 0x012 back-to-back.
- Bubble collapse: feed 0x0A1 then idle 2 cycles then 0x0A2, out_ready=0 -> in_ready stays 1 until 5 words are held; occupancy counts 1..5; once 5 are held, in_ready=0, out_data=0x0A1 stable, stalled=1.
- Full with simultaneous in/out: pipeline full of 0x100..0x104, out_ready=1 and in_valid=1 with 0x105 -> 0x100 retires, 0x105 accepted same cycle, occupancy stays 5.
- Flush while stalled: full with 0x1F0..0x1F4, out_ready=0, pulse flush -> out_valid=0 and in_ready=0 during flush, occupancy=0 next cycle; next input 0x055 emerges 5 cycles later, 0x1F0..0x1F4 never emitted.
- Randomised valid/ready with a scoreboard: output sequence equals accepted input sequence, and out_data never changes while stalled=1.

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// Shared constants and types for the elastic five-stage instruction pipeline.
package elastic_pipe_pkg;

    localparam int ST_FETCH     = 0;
    localparam int ST_DECODE    = 1;
    localparam int ST_OPERANDS  = 2;
    localparam int ST_EXECUTE   = 3;
    localparam int ST_WRITEBACK = 4;

    localparam int NUM_STAGES    = ST_WRITEBACK + 1;
    localparam int DEFAULT_WIDTH = 9;

    typedef logic [DEFAULT_WIDTH-1:0] instr_t;

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus payload, loading whenever the
// slot is empty or its downstream neighbour is ready.
module elastic_pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    // An empty slot can always take a word, which is what lets bubbles collapse.
    assign rdy = down_ready || !valid;

    // NOTE: the payload register is reset alongside valid so out_data reads 0
    // after reset; every other update uses non-blocking assignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (rdy) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_stage_pipeline.sv
// Fetch..writeback pipeline with per-stage valid/ready handshakes, a
// synchronous flush for branch redirects and a registered occupancy count.
module elastic_stage_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = NUM_STAGES,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy,
    output logic             stalled
);

    logic             valid [DEPTH];
    logic [WIDTH-1:0] data  [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             stage_up_valid;
        logic [WIDTH-1:0] stage_up_data;
        logic             stage_down_ready;
        logic             stage_rdy;

        if (i == ST_FETCH) begin : g_src
            assign stage_up_valid = in_valid;
            assign stage_up_data  = in_data;
        end else begin : g_chain
            assign stage_up_valid = valid[i-1];
            assign stage_up_data  = data[i-1];
        end

        // Ready ripples backward from the consumer through each slot.
        if (i == DEPTH - 1) begin : g_tail
            assign stage_down_ready = out_ready;
        end else begin : g_mid
            assign stage_down_ready = g_stage[i+1].stage_rdy;
        end

        elastic_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (stage_up_valid),
            .up_data    (stage_up_data),
            .down_ready (stage_down_ready),
            .valid      (valid[i]),
            .data       (data[i]),
            .rdy        (stage_rdy)
        );
    end

    logic in_fire;
    logic out_fire;

    // Flush blocks both handshakes in the cycle it is asserted.
    assign in_ready  = g_stage[ST_FETCH].stage_rdy && !flush;
    assign out_valid = valid[DEPTH-1] && !flush;
    assign out_data  = data[DEPTH-1];
    assign stalled   = out_valid && !out_ready;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Tracks popcount(valid) incrementally: +1 per accept, -1 per retire.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!in_fire && out_fire) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule
